// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line bundle between the UART register block and the serializer.
interface uart_tx_serializer_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_uart_tx;
    logic       o_busy;

    // Producer side: offers bytes, observes the serializer status and line.
    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_uart_tx,
        input  o_busy
    );

    // Serializer side.
    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_uart_tx,
        output o_busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it out LSB first.
// The final cycle of the stop bit is spent in IDLE (line high, ready high), so a
// waiting producer is accepted exactly on the next bit boundary and frames tile
// at 10*CLKS_PER_BIT cycles with no idle gap.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q,    tx_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;

    // Next-state and next-output logic; every register holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && ready_q) begin
                    state_d = S_START;
                    shift_d = bus.i_data;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                // Last stop-bit cycle is served by IDLE, hence one count short here.
                if (cnt_q == CNT_STOP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any frame and wins over a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_uart_tx = tx_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with CLKS_PER_BIT=4.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_serializer_if bus();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level reference: expected line and ready per cycle, plus scoreboard of accepted bytes.
    bit         m_on    = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_ready = 1'b1;
    int         m_pos   = 0;
    logic [9:0] m_frame = '1;
    logic [7:0] sb_q[$];
    bit         rx_clear = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_on     = 1'b1;
            m_busy   = 1'b0;
            m_pos    = 0;
            rx_clear = 1'b1;
            sb_q.delete();
        end else if (m_on) begin
            if (m_ready && bus.i_valid) begin
                m_busy  = 1'b1;
                m_pos   = 0;
                m_frame = {1'b1, bus.i_data, 1'b0};
                sb_q.push_back(bus.i_data);
            end else if (m_busy) begin
                m_pos++;
                if (m_pos == FRAME) m_busy = 1'b0;
            end
        end
        m_ready = !m_busy || (m_pos == FRAME - 1);
    end

    // Per-cycle checks and a line receiver that pops the scoreboard on each decoded frame.
    int         rx_st = 0;
    int         rx_c  = 0;
    logic [7:0] rx_b  = '0;

    always @(negedge clk) begin
        logic e_tx;
        int   slot;
        if (m_on) begin
            e_tx = m_busy ? m_frame[4'(m_pos / CPB)] : 1'b1;
            chk("line", 32'(bus.o_uart_tx), 32'(e_tx));
            chk("ready", 32'(bus.o_ready), 32'(m_ready));
            chk("busy_vs_ready", 32'(bus.o_busy), 32'(!bus.o_ready));
            if (bus.o_ready) chk("idle_line_high", 32'(bus.o_uart_tx), 32'd1);

            if (rx_clear) begin
                rx_st    = 0;
                rx_clear = 1'b0;
            end
            if (rx_st == 0) begin
                if (bus.o_uart_tx == 1'b0) begin
                    rx_st = 1;
                    rx_c  = 0;
                end
            end else begin
                rx_c++;
                if (rx_c % CPB == CPB / 2) begin
                    slot = rx_c / CPB;
                    if (slot == 0) begin
                        chk("rx_start_bit", 32'(bus.o_uart_tx), 32'd0);
                    end else if (slot <= 8) begin
                        rx_b[3'(slot - 1)] = bus.o_uart_tx;
                    end else begin
                        chk("rx_stop_bit", 32'(bus.o_uart_tx), 32'd1);
                        if (sb_q.size() == 0) begin
                            chk("sb_unexpected_frame", 32'(rx_b), 32'hFFFF_FFFF);
                        end else begin
                            chk("sb_byte", 32'(rx_b), 32'(sb_q.pop_front()));
                        end
                        rx_st = 0;
                    end
                end
            end
        end
    end

    // Caller sits at a negedge; offers d for exactly one rising edge.
    task automatic send_pulse(input logic [7:0] d);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Samples each bit slot at mid-bit for n frames and reports when ready returns.
    task automatic run_frames(input int n, output logic [19:0] cap, output int rdy_at);
        cap    = '0;
        rdy_at = -1;
        for (int c = 0; c < n * FRAME + 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c < n * FRAME && (c % CPB) == CPB / 2) cap[5'(c / CPB)] = bus.o_uart_tx;
            if (rdy_at < 0 && c >= (n - 1) * FRAME && bus.o_ready) rdy_at = c + 1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line value per bit slot, slot 0 = start bit
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [19:0] cap;
        int          rdy_at;
        int          lows;

        vecs[0] = '{data: 8'h55, frame: 10'b1_01010101_0};
        vecs[1] = '{data: 8'hA3, frame: 10'b1_10100011_0};
        vecs[2] = '{data: 8'h00, frame: 10'b1_00000000_0};
        vecs[3] = '{data: 8'hFF, frame: 10'b1_11111111_0};
        vecs[4] = '{data: 8'h81, frame: 10'b1_10000001_0};

        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(bus.o_uart_tx), 32'd1);
        chk("reset_ready", 32'(bus.o_ready), 32'd1);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);

        // Single frames from idle.
        for (int i = 0; i < 5; i++) begin
            send_pulse(vecs[i].data);
            run_frames(1, cap, rdy_at);
            chk($sformatf("frame_%02h", vecs[i].data), 32'(cap[9:0]), 32'(vecs[i].frame));
            chk($sformatf("ready_delay_%02h", vecs[i].data), 32'(rdy_at), 32'(FRAME));
        end

        // Back-to-back 0x00 then 0xFF with valid held: no gap, 80 cycles total.
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h00;
        @(negedge clk);
        bus.i_data = 8'hFF;
        fork
            begin
                repeat (FRAME) @(negedge clk);
                bus.i_valid = 1'b0;
            end
        join_none
        run_frames(2, cap, rdy_at);
        chk("b2b_frames", 32'(cap), 32'(20'b1_11111111_0_1_00000000_0));
        chk("b2b_total", 32'(rdy_at), 32'(2 * FRAME));

        // Mid-frame data change and valid pulse must be ignored.
        send_pulse(8'hA3);
        fork
            begin
                repeat (5) @(negedge clk);
                bus.i_data = 8'h00;
                repeat (7) @(negedge clk);
                bus.i_valid = 1'b1;
                @(negedge clk);
                bus.i_valid = 1'b0;
            end
        join_none
        run_frames(1, cap, rdy_at);
        chk("ignore_frame", 32'(cap[9:0]), 32'(10'b1_10100011_0));
        chk("ignore_ready", 32'(rdy_at), 32'(FRAME));
        chk("ignore_no_pending", 32'(sb_q.size()), 32'd0);

        // Reset during data bit 3 of 0xF0, then 0x81 right away.
        send_pulse(8'hF0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", 32'(bus.o_uart_tx), 32'd1);
        chk("abort_ready", 32'(bus.o_ready), 32'd1);
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        send_pulse(8'h81);
        run_frames(1, cap, rdy_at);
        chk("after_abort_frame", 32'(cap[9:0]), 32'(10'b1_10000001_0));
        chk("after_abort_ready", 32'(rdy_at), 32'(FRAME));

        // Reset and valid on the same edge: nothing is sent.
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h3C;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        lows = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (bus.o_uart_tx !== 1'b1) lows++;
        end
        chk("rst_vs_valid_low_cycles", 32'(lows), 32'd0);
        chk("rst_vs_valid_ready", 32'(bus.o_ready), 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        chk("rx_idle_at_end", 32'(rx_st), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port i_data, input, 8 bits: byte to transmit; sampled only at handshake.
REQ-005 SHALL have port i_valid, input, 1 bit: producer (memory-mapped UART register block) offers i_data.
REQ-006 SHALL have port o_ready, output, 1 bit: serializer can accept a byte this cycle.
REQ-007 SHALL have port o_uart_tx, output, 1 bit: serial line, idle-high, 8N1 framing.
REQ-008 SHALL have port o_busy, output, 1 bit: frame in progress (== !o_ready).

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP; all outputs driven from registers (no combinational path to o_uart_tx).
REQ-010 SHALL assert o_ready only in IDLE.
REQ-011 SHALL accept a byte at a rising edge where i_valid=1 and o_ready=1; accepted byte latched into an internal shift register.
REQ-012 SHALL, on accept, move IDLE->START at that same edge, driving o_uart_tx=0 and o_ready=0 from that edge.
REQ-013 SHALL hold each bit (start, 8 data, stop) on o_uart_tx for exactly CLKS_PER_BIT cycles, using a baud counter of width ceil(log2(CLKS_PER_BIT)) reset to 0 at every bit boundary.
REQ-014 SHALL transmit data bits LSB first in DATA, with a 3-bit index counting 0..7; DATA->STOP after bit 7 completes.
REQ-015 SHALL drive o_uart_tx=1 in STOP for CLKS_PER_BIT cycles, then return to IDLE with o_ready=1.
REQ-016 SHALL reassert o_ready exactly 10*CLKS_PER_BIT cycles after the accepting edge.
REQ-017 SHALL ignore i_valid and i_data while o_ready=0; changes to i_data after accept SHALL NOT affect the frame in progress.
REQ-018 SHALL support back-to-back frames: if i_valid=1 on the first IDLE cycle after STOP, next start bit begins at that edge with no extra idle gap.
REQ-019 SHALL, with i_valid held high continuously, send one frame per 10*CLKS_PER_BIT cycles (level-valid producer repeats the byte).
REQ-020 SHALL keep o_uart_tx=1 in IDLE indefinitely.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, enter IDLE with o_uart_tx=1, o_ready=1, o_busy=0, baud counter=0, bit index=0, shift register=0x00.
REQ-022 SHALL abort any frame in progress on reset (including mid-start, mid-data, mid-stop); line high from the next cycle, no partial bits afterwards.
REQ-023 SHALL give rst priority over a simultaneous i_valid handshake (byte not accepted).

Verification (CLKS_PER_BIT=4)
REQ-024 SHALL pass: reset, then i_valid=1, i_data=0x55 for one cycle -> o_uart_tx pattern 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; o_ready high again 40 cycles after accept.
REQ-025 SHALL pass: send 0x00 then 0xFF back-to-back with i_valid held -> 9 low bits + stop, then start + 8 high + stop; no idle cycle between frames; total 80 cycles.
REQ-026 SHALL pass: accept 0xA3, then change i_data to 0x00 and pulse i_valid during frame -> line carries 0xA3 LSB-first (1,1,0,0,0,1,0,1); second request ignored.
REQ-027 SHALL pass: assert rst during data bit 3 of 0xF0 -> next cycle o_uart_tx=1, o_ready=1; new byte 0x81 accepted immediately afterwards and transmitted correctly.
REQ-028 SHALL pass: rst=1 and i_valid=1 on same edge -> no frame started; line stays high for 40 cycles with i_valid=0.
REQ-029 SHALL pass: checker asserting o_busy == !o_ready and o_uart_tx==1 whenever in IDLE, every cycle of all scenarios.
